c499_key_stage: RTL and testbench
=================================

Name: c499_key_stage

Overview:
- Sequential front end directly upstream of the obfuscated c499 32-bit SEC decoder core.
- Serially loads and verifies the 2-bit unlock key, then drives the core's key inputs.
- Stages data words and check bytes into the core through a valid/ready register slice.
- Keeps key outputs and data enable inert until a verified key is armed.

Parameters:
- DATA_W, 32, data word width, core inputs N1..N125.
- CHK_W, 8, check-bit width, core inputs N129..N136.
- KEY_W, 2, key width, core inputs D_0, D_1.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- key_shift_i  in  1  qualifies key_ser_i for one shift
- key_ser_i  in  1  serial key bit, LSB first
- key_par_i  in  1  even-parity bit over the key, sampled in VERIFY
- key_clr_i  in  1  synchronous clear of key and FSM to IDLE
- in_valid_i  in  1  upstream word valid
- in_ready_o  out  1  block can accept a word
- in_data_i  in  DATA_W  data word
- in_chk_i  in  CHK_W  received check bits
- core_data_o  out  DATA_W  to N1..N125, bit k drives N(1+4k)
- core_chk_o  out  CHK_W  to N129..N136
- core_en_o  out  1  to N137
- core_key_o  out  KEY_W  to D_1..D_0
- out_valid_o  out  1  core output valid toward consumer
- out_ready_i  in  1  consumer accepts core output
- state_o  out  2  FSM state, for debug
- fault_o  out  1  sticky key-verify fault

Behaviour:
- Reset: rst_n is an asynchronous, active-low reset on a single clock, clk.
- Reset values: all outputs 0; state IDLE; key shift register 0.
- FSM states: IDLE=0, LOAD=1, VERIFY=2, ARMED=3.
- FAULT is not a separate state: it is IDLE with fault_o=1.
- IDLE -> LOAD on the first key_shift_i; that bit is shifted in.
- LOAD: each key_shift_i shifts key_ser_i into bit[cnt]. The counter cnt runs 0..KEY_W-1. After KEY_W shifts, go to VERIFY.
- LOAD: key_shift_i low means hold.
- VERIFY lasts one cycle. If the XOR of the key bits and key_par_i equals 0, go to ARMED: core_key_o is loaded and fault_o cleared.
- VERIFY on a parity mismatch: go to IDLE, fault_o=1, key register zeroed.
- ARMED: key_shift_i ignored; core_key_o held stable.
- key_clr_i in any state: next cycle IDLE, key=0, core_key_o=0, out_valid_o=0, staged word dropped. fault_o is kept.
- key_clr_i has priority over every other event in the same cycle.
- in_ready_o = ARMED && (!out_valid_o || out_ready_i).
- Handshake: a transfer occurs when in_valid_i && in_ready_o. On the next edge, core_data_o, core_chk_o and core_en_o=1 are registered, and out_valid_o=1.
- Latency is 1 cycle from accept to core inputs. The core is combinational, so its outputs are valid when out_valid_o=1.
- Handshake: out_valid_o && out_ready_i without a new accept clears out_valid_o and core_en_o.
- Handshake: a simultaneous consume and accept keeps out_valid_o=1 with the new word, giving full throughput.
- Staged data stays unchanged while out_valid_o && !out_ready_i.
- Leaving ARMED (via key_clr_i only) drops the stage.
- Reset mid-LOAD or mid-transfer: everything is cleared immediately, because reset is asynchronous.

Optional Feature:
- Macro: C499_KEY_STAGE_ENC_CHK_EN.
- Defined: in_chk_i is ignored. core_chk_o[i] is computed at accept as the XOR-reduction of in_data_i & CHK_MASK[i], so the core sees a zero syndrome and passes data through uncorrected. Intended for self-test.
- Undefined: in_chk_i is passed straight through.

Decomposition:
- Package c499_stage_pkg holds:
  - state enum
  - DATA_W / CHK_W / KEY_W constants
  - CHK_MASK[0..7] 32-bit constants; CHK_MASK[0] = data bits {0,4,8,12,16..23}, with the rest per the core's syndrome equations.
- One sub-module, c499_key_loader: FSM, counter, shift register, parity check.
- The top holds the register slice.

Test Plan:
- Key load: shift bits 1,1 with key_par_i=0 -> VERIFY then ARMED in cycle 3; core_key_o=2'b11; fault_o=0.
- Bad parity: shift bits 1,0 with key_par_i=0 -> IDLE, fault_o=1, core_key_o=0, in_ready_o=0.
- Streaming: ARMED, out_ready_i=1, words 0x00000001, 0xFFFFFFFF back-to-back -> core_data_o shows each word one cycle after accept; out_valid_o stays 1 for 2 cycles.
- Backpressure: out_ready_i=0 with out_valid_o=1 -> in_ready_o=0; core_data_o held for 5 cycles. Release -> word consumed, next word accepted in the same cycle.
- Clear mid-stream: key_clr_i while out_valid_o=1 -> next cycle out_valid_o=0, core_en_o=0, core_key_o=0, state_o=0.
- With C499_KEY_STAGE_ENC_CHK_EN: data 0x00000001 -> core_chk_o[0]=1; data 0x00010000 -> core_chk_o[0]=1; core output equals input data.

Source files
------------

// File: rtl/c499_stage_pkg.sv
// rtl/c499_stage_pkg.sv - shared types and constants for the c499 key/data front end
//
// Contents:
//   DATA_W / CHK_W / KEY_W  widths of the core data, check and key inputs
//   state_e                 key FSM encoding (IDLE=0, LOAD=1, VERIFY=2, ARMED=3)
//   CHK_MASK[i]             data bits covered by syndrome bit i of the core
//   enc_chk()               check bits that give the core a zero syndrome
package c499_stage_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int KEY_W  = 2;
  localparam int CNT_W  = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_ARMED  = 2'd3
  } state_e;

  // Low four masks: one nibble column of the low half-word plus a full high byte.
  // High four masks: one nibble column of the high half-word plus a full low byte.
  localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASK = {
    32'h8888_FF00,  // [7]
    32'h4444_00FF,  // [6]
    32'h2222_FF00,  // [5]
    32'h1111_00FF,  // [4]
    32'hFF00_8888,  // [3]
    32'h00FF_4444,  // [2]
    32'hFF00_2222,  // [1]
    32'h00FF_1111   // [0] bits {0,4,8,12,16..23}
  };

  function automatic logic [CHK_W-1:0] enc_chk(input logic [DATA_W-1:0] data);
    logic [CHK_W-1:0] chk;
    for (int i = 0; i < CHK_W; i++) begin
      chk[i] = ^(data & CHK_MASK[i]);
    end
    return chk;
  endfunction

endpackage

// File: rtl/c499_key_loader.sv
// rtl/c499_key_loader.sv - serial key load, parity verify and arming FSM
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   key_shift_i     qualifies key_ser_i for one shift
//   key_ser_i       serial key bit, LSB first
//   key_par_i       even-parity bit over the key, sampled in VERIFY
//   key_clr_i       synchronous clear to IDLE (fault is kept)
//   state_o         current FSM state
//   key_o           verified key toward the core (0 unless armed)
//   fault_o         sticky key-verify fault
//   armed_o         state is ARMED
module c499_key_loader
  import c499_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_shift_i,
  input  logic             key_ser_i,
  input  logic             key_par_i,
  input  logic             key_clr_i,
  output logic [1:0]       state_o,
  output logic [KEY_W-1:0] key_o,
  output logic             fault_o,
  output logic             armed_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [KEY_W-1:0]  shreg_q, shreg_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              fault_q, fault_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      key_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      key_q   <= key_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    key_d   = key_q;
    fault_d = fault_q;

    if (key_clr_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      shreg_d = '0;
      key_d   = '0;
    end else begin
      case (state_q)
        // IDLE and LOAD share the shift path; cnt is 0 whenever IDLE is entered.
        ST_IDLE, ST_LOAD: begin
          if (key_shift_i) begin
            shreg_d[cnt_q] = key_ser_i;
            if (cnt_q == CNT_W'(KEY_W - 1)) begin
              cnt_d   = '0;
              state_d = ST_VERIFY;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ST_LOAD;
            end
          end
        end
        ST_VERIFY: begin
          if (((^shreg_q) ^ key_par_i) == 1'b0) begin
            state_d = ST_ARMED;
            key_d   = shreg_q;
            fault_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            shreg_d = '0;
            key_d   = '0;
            fault_d = 1'b1;
          end
        end
        ST_ARMED: begin
          state_d = ST_ARMED;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          shreg_d = '0;
          key_d   = '0;
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign key_o   = key_q;
  assign fault_o = fault_q;
  assign armed_o = (state_q == ST_ARMED);

endmodule

// File: rtl/c499_key_stage.sv
// rtl/c499_key_stage.sv - key-gated valid/ready stage feeding the c499 SEC core
//
// Optional feature macro: C499_KEY_STAGE_ENC_CHK_EN
//   defined   -> core_chk_o is generated from the accepted data (zero syndrome)
//   undefined -> in_chk_i is passed through
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   key_shift_i/key_ser_i/key_par_i  serial key load and parity
//   key_clr_i                        clear key, FSM and staged word
//   in_valid_i/in_ready_o            upstream handshake
//   in_data_i/in_chk_i               data word and received check bits
//   core_data_o/core_chk_o/core_en_o staged core inputs (N1..N137)
//   core_key_o                       core key inputs (D_1..D_0)
//   out_valid_o/out_ready_i          downstream handshake
//   state_o, fault_o                 FSM state and sticky verify fault
module c499_key_stage
  import c499_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_shift_i,
  input  logic              key_ser_i,
  input  logic              key_par_i,
  input  logic              key_clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CHK_W-1:0]  in_chk_i,
  output logic [DATA_W-1:0] core_data_o,
  output logic [CHK_W-1:0]  core_chk_o,
  output logic              core_en_o,
  output logic [KEY_W-1:0]  core_key_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [1:0]        state_o,
  output logic              fault_o
);

  logic              armed;
  logic              accept;
  logic [CHK_W-1:0]  chk_in;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CHK_W-1:0]  chk_q, chk_d;

  c499_key_loader u_key_loader (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_shift_i (key_shift_i),
    .key_ser_i   (key_ser_i),
    .key_par_i   (key_par_i),
    .key_clr_i   (key_clr_i),
    .state_o     (state_o),
    .key_o       (core_key_o),
    .fault_o     (fault_o),
    .armed_o     (armed)
  );

`ifdef C499_KEY_STAGE_ENC_CHK_EN
  assign chk_in = enc_chk(in_data_i);
`else
  assign chk_in = in_chk_i;
`endif

  // The stage can take a new word whenever its current one leaves this cycle.
  assign in_ready_o = armed && (!valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chk_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chk_q   <= chk_d;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    chk_d   = chk_q;
    if (key_clr_i) begin
      // Clear wins over a same-cycle accept; the staged word is discarded.
      valid_d = 1'b0;
      data_d  = '0;
      chk_d   = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
      chk_d   = chk_in;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign core_data_o = data_q;
  assign core_chk_o  = chk_q;
  assign core_en_o   = valid_q;
  assign out_valid_o = valid_q;

endmodule

// File: tb/tb_c499_key_stage.sv
// tb/tb_c499_key_stage.sv - self-checking bench for c499_key_stage
module tb_c499_key_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_shift_i, key_ser_i, key_par_i, key_clr_i;
  logic        in_valid_i, in_ready_o;
  logic [31:0] in_data_i;
  logic [7:0]  in_chk_i;
  logic [31:0] core_data_o;
  logic [7:0]  core_chk_o;
  logic        core_en_o;
  logic [1:0]  core_key_o;
  logic        out_valid_o, out_ready_i;
  logic [1:0]  state_o;
  logic        fault_o;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  // Bench model: armed flag and queue of {chk, data} expected at the core.
  logic        armed_m = 1'b0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  c499_key_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_shift_i (key_shift_i),
    .key_ser_i   (key_ser_i),
    .key_par_i   (key_par_i),
    .key_clr_i   (key_clr_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_chk_i    (in_chk_i),
    .core_data_o (core_data_o),
    .core_chk_o  (core_chk_o),
    .core_en_o   (core_en_o),
    .core_key_o  (core_key_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .state_o     (state_o),
    .fault_o     (fault_o)
  );

  // Drives a full key load (KEY_W shifts, then the VERIFY cycle); no checks.
  task automatic shift_key(input logic b0, input logic b1, input logic par);
    @(negedge clk); key_shift_i = 1'b1; key_ser_i = b0;
    @(negedge clk); key_ser_i = b1;
    @(negedge clk); key_shift_i = 1'b0; key_ser_i = 1'b0; key_par_i = par;
    @(negedge clk); key_par_i = 1'b0;
  endtask

  // Stream stimulus through the stage; ready/valid/data per step.
  task automatic run_steps(input string tag, input int n,
                           input logic [31:0] dat [16], input logic vld [16],
                           input logic rdy [16]);
    logic exp_ready;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid_o !== (exp_q.size() != 0))
        $display("FAIL %s out_valid step %0d: got %b want %b", tag, i, out_valid_o, exp_q.size() != 0);
      else n_pass++;
      if (exp_q.size() != 0) begin
        n_chk++;
        if (core_data_o !== exp_q[0][31:0])
          $display("FAIL %s core_data step %0d: got %h want %h", tag, i, core_data_o, exp_q[0][31:0]);
        else n_pass++;
        n_chk++;
        if (core_en_o !== 1'b1)
          $display("FAIL %s core_en step %0d: got %b want 1", tag, i, core_en_o);
        else n_pass++;
`ifndef C499_KEY_STAGE_ENC_CHK_EN
        n_chk++;
        if (core_chk_o !== exp_q[0][39:32])
          $display("FAIL %s core_chk step %0d: got %h want %h", tag, i, core_chk_o, exp_q[0][39:32]);
        else n_pass++;
`endif
      end
      if (i < n) begin
        out_ready_i = rdy[i];
        in_valid_i  = vld[i];
        in_data_i   = dat[i];
        in_chk_i    = dat[i][7:0] ^ 8'h5A;
        exp_ready   = armed_m && (exp_q.size() == 0 || rdy[i]);
        #1;
        n_chk++;
        if (in_ready_o !== exp_ready)
          $display("FAIL %s in_ready step %0d: got %b want %b", tag, i, in_ready_o, exp_ready);
        else n_pass++;
        if (exp_q.size() != 0 && rdy[i]) void'(exp_q.pop_front());
        if (vld[i] && exp_ready) exp_q.push_back({dat[i][7:0] ^ 8'h5A, dat[i]});
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_shift_i = 0; key_ser_i = 0; key_par_i = 0; key_clr_i = 0;
    in_valid_i = 0; in_data_i = '0; in_chk_i = '0; out_ready_i = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({state_o, core_key_o, fault_o, out_valid_o, core_en_o, in_ready_o} !== 8'h00)
      $display("FAIL reset_ctrl: got %b want 00000000",
               {state_o, core_key_o, fault_o, out_valid_o, core_en_o, in_ready_o});
    else n_pass++;
    n_chk++;
    if ({core_data_o, core_chk_o} !== 40'h0)
      $display("FAIL reset_data: got %h want 0", {core_data_o, core_chk_o});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_key_load();
    @(negedge clk); key_shift_i = 1'b1; key_ser_i = 1'b1;
    @(negedge clk);
    n_chk++;
    if (state_o !== 2'd1) $display("FAIL load_state: got %0d want 1", state_o); else n_pass++;
    key_shift_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (state_o !== 2'd1) $display("FAIL load_hold: got %0d want 1", state_o); else n_pass++;
    key_shift_i = 1'b1; key_ser_i = 1'b1;
    @(negedge clk);
    n_chk++;
    if (state_o !== 2'd2) $display("FAIL verify_state: got %0d want 2", state_o); else n_pass++;
    key_shift_i = 1'b0; key_par_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({state_o, core_key_o, fault_o, in_ready_o} !== 6'b11_11_0_1)
      $display("FAIL armed: got %b want 111101", {state_o, core_key_o, fault_o, in_ready_o});
    else n_pass++;
    armed_m = 1'b1;
    // Shifts while armed must not disturb the key.
    key_shift_i = 1'b1; key_ser_i = 1'b0;
    repeat (2) @(negedge clk);
    key_shift_i = 1'b0;
    n_chk++;
    if ({state_o, core_key_o} !== 4'b1111)
      $display("FAIL armed_ignore_shift: got %b want 1111", {state_o, core_key_o});
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] dat [16];
    logic        vld [16];
    logic        rdy [16];
    dat[0] = 32'h0000_0001; vld[0] = 1; rdy[0] = 1;
    dat[1] = 32'hFFFF_FFFF; vld[1] = 1; rdy[1] = 1;
    dat[2] = 32'h0;         vld[2] = 0; rdy[2] = 1;
    run_steps("stream", 3, dat, vld, rdy);
  endtask

  task automatic test_back_to_back();
    logic [31:0] dat [16];
    logic        vld [16];
    logic        rdy [16];
    dat[0] = 32'h1234_5678; vld[0] = 1; rdy[0] = 0;
    for (int i = 1; i <= 5; i++) begin
      dat[i] = 32'hCAFE_F00D; vld[i] = 1; rdy[i] = 0;
    end
    dat[6] = 32'hCAFE_F00D; vld[6] = 1; rdy[6] = 1;
    dat[7] = 32'h0;         vld[7] = 0; rdy[7] = 1;
    run_steps("backpressure", 8, dat, vld, rdy);
  endtask

  task automatic test_clear();
    @(negedge clk);
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hA5A5_0F0F; in_chk_i = 8'h3C;
    @(negedge clk);
    in_valid_i = 1'b0;
    n_chk++;
    if (out_valid_o !== 1'b1) $display("FAIL clear_pre_valid: got %b want 1", out_valid_o); else n_pass++;
    key_clr_i = 1'b1;
    in_valid_i = 1'b1; in_data_i = 32'h7777_7777;
    @(negedge clk);
    key_clr_i = 1'b0; in_valid_i = 1'b0;
    exp_q.delete();
    armed_m = 1'b0;
    n_chk++;
    if ({out_valid_o, core_en_o, core_key_o, state_o, fault_o, in_ready_o} !== 8'h00)
      $display("FAIL clear_mid_stream: got %b want 00000000",
               {out_valid_o, core_en_o, core_key_o, state_o, fault_o, in_ready_o});
    else n_pass++;
  endtask

  task automatic test_bad_parity();
    shift_key(1'b1, 1'b0, 1'b0);
    n_chk++;
    if ({state_o, fault_o, core_key_o, in_ready_o} !== 6'b00_1_00_0)
      $display("FAIL bad_parity: got %b want 001000", {state_o, fault_o, core_key_o, in_ready_o});
    else n_pass++;
    key_clr_i = 1'b1;
    @(negedge clk);
    key_clr_i = 1'b0;
    n_chk++;
    if (fault_o !== 1'b1) $display("FAIL fault_sticky_clr: got %b want 1", fault_o); else n_pass++;
    // Key bits 0,1 (key=2'b10) with odd parity bit 1 -> even overall.
    shift_key(1'b0, 1'b1, 1'b1);
    n_chk++;
    if ({state_o, fault_o, core_key_o} !== 5'b11_0_10)
      $display("FAIL rearm: got %b want 11010", {state_o, fault_o, core_key_o});
    else n_pass++;
    armed_m = 1'b1;
  endtask

`ifdef C499_KEY_STAGE_ENC_CHK_EN
  task automatic test_enc_chk();
    logic [31:0] words [2];
    words[0] = 32'h0000_0001;
    words[1] = 32'h0001_0000;
    out_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid_i = 1'b1; in_data_i = words[i]; in_chk_i = 8'h00;
      @(negedge clk);
      in_valid_i = 1'b0;
      n_chk++;
      if (core_chk_o[0] !== 1'b1) $display("FAIL enc_chk0 word %0d: got %b want 1", i, core_chk_o[0]);
      else n_pass++;
      n_chk++;
      if (core_data_o !== words[i]) $display("FAIL enc_data word %0d: got %h want %h", i, core_data_o, words[i]);
      else n_pass++;
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_async_reset();
    @(negedge clk);
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    in_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid_o, core_en_o, core_key_o, state_o} !== 6'b0)
      $display("FAIL async_reset_xfer: got %b want 000000", {out_valid_o, core_en_o, core_key_o, state_o});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    armed_m = 1'b0;
    exp_q.delete();
    key_shift_i = 1'b1; key_ser_i = 1'b1;
    @(negedge clk);
    key_shift_i = 1'b0;
    n_chk++;
    if (state_o !== 2'd1) $display("FAIL pre_reset_load: got %0d want 1", state_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({state_o, core_key_o, fault_o} !== 5'b0)
      $display("FAIL async_reset_load: got %b want 00000", {state_o, core_key_o, fault_o});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    // After reset the counter must restart at bit 0: load 1,1 again.
    shift_key(1'b1, 1'b1, 1'b0);
    n_chk++;
    if ({state_o, core_key_o} !== 4'b1111)
      $display("FAIL reload_after_reset: got %b want 1111", {state_o, core_key_o});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_stream();
    test_back_to_back();
    test_clear();
    test_bad_parity();
`ifdef C499_KEY_STAGE_ENC_CHK_EN
    test_enc_chk();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
